// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl
// Sequences one voting session: collects a serially keyed 4-digit PIN,
// verifies it against ref_pin, opens a single ballot, and emits a one-cycle
// one-hot increment strobe to the tally counters. Repeated PIN failures lock
// the keypad for LOCK_CYCLES cycles; idle PIN entry or an idle ballot is
// aborted after TIMEOUT cycles. Once the poll is closed the controller stays
// in CLOSED until reset and enables the results display.
//
// Ports
//   clk           system clock (rising edge)
//   rst_n         asynchronous active-low reset
//   digit_valid   one-cycle strobe qualifying digit
//   digit[3:0]    keyed PIN digit
//   ref_pin[15:0] reference PIN, first keyed digit compared against [15:12]
//   btn[3:0]      candidate buttons (level), bit i = candidate i+1
//   close_poll    level request to end polling
//   vote_inc[3:0] one-hot, one-cycle tally increment strobe
//   ballot_open   high while a ballot is open
//   pin_err       one-cycle pulse on PIN mismatch
//   locked        high while the keypad is locked out
//   show_results  high once the poll is closed
//   voters[7:0]   ballots cast, saturating at 255
//   state[2:0]    current state encoding (debug)
//
// state  | meaning
// IDLE   | waiting for first digit or close_poll
// ENTRY  | collecting digits 2..4
// BALLOT | ballot open, waiting for an armed one-hot button
// CAST   | vote_inc strobe cycle, voter count update
// LOCKED | keypad locked after MAX_FAILS consecutive PIN failures
// CLOSED | poll closed, terminal until reset

module vote_session_ctrl #(
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic [15:0] ref_pin,
    input  logic [3:0]  btn,
    input  logic        close_poll,
    output logic [3:0]  vote_inc,
    output logic        ballot_open,
    output logic        pin_err,
    output logic        locked,
    output logic        show_results,
    output logic [7:0]  voters,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_BALLOT = 3'd2,
        S_CAST   = 3'd3,
        S_LOCKED = 3'd4,
        S_CLOSED = 3'd5
    } state_t;

    // One down-counter serves both the entry/ballot timeout and the lockout.
    localparam int TMAX = (TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] LK_LOAD = TW'(LOCK_CYCLES - 1);
    localparam logic [3:0]    MF      = 4'(MAX_FAILS);

    state_t        st;
    logic [11:0]   pin_buf;
    logic [1:0]    dcnt;
    logic [3:0]    fail_cnt;
    logic [TW-1:0] timer;
    logic          armed;
    logic          btn_onehot;
    logic [3:0]    fail_nxt;

    assign btn_onehot = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
    assign fail_nxt   = fail_cnt + 4'd1;
    assign state      = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= S_IDLE;
            pin_buf      <= '0;
            dcnt         <= '0;
            fail_cnt     <= '0;
            timer        <= '0;
            armed        <= 1'b0;
            vote_inc     <= '0;
            ballot_open  <= 1'b0;
            pin_err      <= 1'b0;
            locked       <= 1'b0;
            show_results <= 1'b0;
            voters       <= '0;
        end else begin
            pin_err <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (close_poll) begin
                        show_results <= 1'b1;
                        st           <= S_CLOSED;
                    end else if (digit_valid) begin
                        pin_buf <= {8'h00, digit};
                        dcnt    <= 2'd1;
                        timer   <= TO_LOAD;
                        st      <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (digit_valid) begin
                        if (dcnt == 2'd3) begin
                            dcnt    <= 2'd0;
                            pin_buf <= '0;
                            if ({pin_buf, digit} == ref_pin) begin
                                fail_cnt    <= 4'd0;
                                ballot_open <= 1'b1;
                                armed       <= 1'b0;
                                timer       <= TO_LOAD;
                                st          <= S_BALLOT;
                            end else begin
                                pin_err  <= 1'b1;
                                fail_cnt <= fail_nxt;
                                if (fail_nxt == MF) begin
                                    locked <= 1'b1;
                                    timer  <= LK_LOAD;
                                    st     <= S_LOCKED;
                                end else begin
                                    st <= S_IDLE;
                                end
                            end
                        end else begin
                            pin_buf <= {pin_buf[7:0], digit};
                            dcnt    <= dcnt + 2'd1;
                            timer   <= TO_LOAD;
                        end
                    end else if (timer == '0) begin
                        dcnt    <= 2'd0;
                        pin_buf <= '0;
                        st      <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_BALLOT: begin
                    // A press only counts once a released button has been seen,
                    // so a button held from before the ballot is never reused.
                    if (armed && btn_onehot) begin
                        vote_inc    <= btn;
                        ballot_open <= 1'b0;
                        st          <= S_CAST;
                    end else if (timer == '0) begin
                        ballot_open <= 1'b0;
                        st          <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                        if (btn == 4'd0) begin
                            armed <= 1'b1;
                        end
                    end
                end
                S_CAST: begin
                    vote_inc <= 4'd0;
                    armed    <= 1'b0;
                    if (voters != 8'hFF) begin
                        voters <= voters + 8'd1;
                    end
                    st <= S_IDLE;
                end
                S_LOCKED: begin
                    if (timer == '0) begin
                        locked   <= 1'b0;
                        fail_cnt <= 4'd0;
                        st       <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_CLOSED: begin
                    vote_inc <= 4'd0;
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

endmodule
